reservation_station_add: RTL and testbench

//  Reservation station in front of the add/sub functional unit. Accepts instructions from the

---
 rtl/reservation_station_add_pkg.sv | 22 ++
 rtl/reservation_station_add_rs_entry.sv | 71 +++++++
 rtl/reservation_station_add.sv | 170 +++++++++++++++++
 tb/tb_reservation_station_add.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_add_pkg.sv
// Shared widths, tag/op encodings and the per-entry storage layout for the add/sub
// reservation station.
package reservation_station_add_pkg;

    localparam int DATA_W = 16;
    localparam int TAG_W  = 3;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic              busy;
        logic              op;
        logic [DATA_W-1:0] vj;
        logic [TAG_W-1:0]  qj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qk;
    } rs_entry_t;

endpackage

// File: rtl/reservation_station_add_rs_entry.sv
// One reservation-station entry: issue write with CDB bypass, CDB snoop into
// waiting operands, release on selection, and the ready flag.
module reservation_station_add_rs_entry
    import reservation_station_add_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              i_alloc,
    input  logic              i_free,
    input  logic              i_op,
    input  logic [DATA_W-1:0] i_vj,
    input  logic [TAG_W-1:0]  i_qj,
    input  logic [DATA_W-1:0] i_vk,
    input  logic [TAG_W-1:0]  i_qk,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_data,
    output logic              o_busy,
    output logic              o_op,
    output logic [DATA_W-1:0] o_vj,
    output logic [DATA_W-1:0] o_vk,
    output logic              o_ready
);

    rs_entry_t r_entry;
    logic      w_snoop;

    // Tag 0 means "no producer", so a broadcast carrying it never matches.
    assign w_snoop = i_cdb_valid && (i_cdb_tag != TAG_NONE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_entry <= '0;
        end else if (i_alloc) begin
            r_entry.busy <= 1'b1;
            r_entry.op   <= i_op;
            if (w_snoop && (i_qj == i_cdb_tag)) begin
                r_entry.vj <= i_cdb_data;
                r_entry.qj <= TAG_NONE;
            end else begin
                r_entry.vj <= i_vj;
                r_entry.qj <= i_qj;
            end
            if (w_snoop && (i_qk == i_cdb_tag)) begin
                r_entry.vk <= i_cdb_data;
                r_entry.qk <= TAG_NONE;
            end else begin
                r_entry.vk <= i_vk;
                r_entry.qk <= i_qk;
            end
        end else if (i_free) begin
            r_entry <= '0;
        end else if (r_entry.busy) begin
            if (w_snoop && (r_entry.qj == i_cdb_tag)) begin
                r_entry.vj <= i_cdb_data;
                r_entry.qj <= TAG_NONE;
            end
            if (w_snoop && (r_entry.qk == i_cdb_tag)) begin
                r_entry.vk <= i_cdb_data;
                r_entry.qk <= TAG_NONE;
            end
        end
    end

    assign o_busy  = r_entry.busy;
    assign o_op    = r_entry.op;
    assign o_vj    = r_entry.vj;
    assign o_vk    = r_entry.vk;
    assign o_ready = r_entry.busy && (r_entry.qj == TAG_NONE) && (r_entry.qk == TAG_NONE);

endmodule

// File: rtl/reservation_station_add.sv
// Add/sub reservation station: lowest-free allocation, age-matrix oldest-ready
// selection and a one-deep output register toward the adder.
module reservation_station_add
    import reservation_station_add_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int TAG_BASE = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              issue_op,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [TAG_W-1:0]  issue_qk,
    output logic [TAG_W-1:0]  issue_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              fu_valid,
    input  logic              fu_ready,
    output logic              fu_op,
    output logic [DATA_W-1:0] fu_a,
    output logic [DATA_W-1:0] fu_b,
    output logic [TAG_W-1:0]  fu_tag,
    output logic [2:0]        busy_count
);

    logic [DEPTH-1:0]              w_busy;
    logic [DEPTH-1:0]              w_ready;
    logic [DEPTH-1:0]              w_op;
    logic [DATA_W-1:0]             w_vj [DEPTH];
    logic [DATA_W-1:0]             w_vk [DEPTH];
    logic [DEPTH-1:0]              w_alloc_oh;
    logic [DEPTH-1:0]              w_alloc;
    logic [DEPTH-1:0]              w_sel;
    logic [DEPTH-1:0]              w_free;
    logic                          w_load;
    logic                          w_pick_op;
    logic [DATA_W-1:0]             w_pick_a;
    logic [DATA_W-1:0]             w_pick_b;
    logic [TAG_W-1:0]              w_pick_tag;
    logic [2:0]                    w_busy_cnt;
    // r_older[i][j] set means entry i was issued before entry j.
    logic [DEPTH-1:0][DEPTH-1:0]   r_older;
    logic                          r_fu_valid;
    logic                          r_fu_op;
    logic [DATA_W-1:0]             r_fu_a;
    logic [DATA_W-1:0]             r_fu_b;
    logic [TAG_W-1:0]              r_fu_tag;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        reservation_station_add_rs_entry u_entry (
            .clock       (clock),
            .resetn      (resetn),
            .i_alloc     (w_alloc[g]),
            .i_free      (w_free[g]),
            .i_op        (issue_op),
            .i_vj        (issue_vj),
            .i_qj        (issue_qj),
            .i_vk        (issue_vk),
            .i_qk        (issue_qk),
            .i_cdb_valid (cdb_valid),
            .i_cdb_tag   (cdb_tag),
            .i_cdb_data  (cdb_data),
            .o_busy      (w_busy[g]),
            .o_op        (w_op[g]),
            .o_vj        (w_vj[g]),
            .o_vk        (w_vk[g]),
            .o_ready     (w_ready[g])
        );
    end

    // Descending scan so the last hit is the lowest free index.
    always_comb begin
        w_alloc_oh = '0;
        issue_tag  = TAG_W'(TAG_BASE);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!w_busy[i]) begin
                w_alloc_oh    = '0;
                w_alloc_oh[i] = 1'b1;
                issue_tag     = TAG_W'(TAG_BASE + i);
            end
        end
    end

    assign issue_ready = !(&w_busy);
    assign w_alloc     = w_alloc_oh & {DEPTH{issue_valid && issue_ready}};

    always_comb begin
        w_sel = w_ready;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if ((i != j) && w_ready[j] && r_older[j][i]) begin
                    w_sel[i] = 1'b0;
                end
            end
        end
    end

    assign w_load = (|w_ready) && (!r_fu_valid || fu_ready);
    assign w_free = w_sel & {DEPTH{w_load}};

    always_comb begin
        w_pick_op  = 1'b0;
        w_pick_a   = '0;
        w_pick_b   = '0;
        w_pick_tag = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel[i]) begin
                w_pick_op  = w_op[i];
                w_pick_a   = w_vj[i];
                w_pick_b   = w_vk[i];
                w_pick_tag = TAG_W'(TAG_BASE + i);
            end
        end
    end

    always_comb begin
        w_busy_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_busy_cnt = w_busy_cnt + {2'b00, w_busy[i]};
        end
    end

    // A newly allocated entry becomes younger than every other entry.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_older <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (w_alloc[j] && (i != j)) begin
                        r_older[i][j] <= 1'b1;
                    end else if (w_alloc[i]) begin
                        r_older[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_fu_valid <= 1'b0;
            r_fu_op    <= 1'b0;
            r_fu_a     <= '0;
            r_fu_b     <= '0;
            r_fu_tag   <= '0;
        end else if (w_load) begin
            r_fu_valid <= 1'b1;
            r_fu_op    <= w_pick_op;
            r_fu_a     <= w_pick_a;
            r_fu_b     <= w_pick_b;
            r_fu_tag   <= w_pick_tag;
        end else if (fu_ready) begin
            r_fu_valid <= 1'b0;
        end
    end

    assign fu_valid   = r_fu_valid;
    assign fu_op      = r_fu_op;
    assign fu_a       = r_fu_a;
    assign fu_b       = r_fu_b;
    assign fu_tag     = r_fu_tag;
    assign busy_count = w_busy_cnt;

endmodule

// File: tb/tb_reservation_station_add.sv
// Directed scenarios followed by random traffic, all checked every cycle against an
// issue-order reservation-station model.
module tb_reservation_station_add;
    import reservation_station_add_pkg::*;

    localparam int DEPTH   = 3;
    localparam int TB_BASE = 1;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              issue_valid = 1'b0;
    logic              issue_ready;
    logic              issue_op = 1'b0;
    logic [DATA_W-1:0] issue_vj = '0;
    logic [TAG_W-1:0]  issue_qj = '0;
    logic [DATA_W-1:0] issue_vk = '0;
    logic [TAG_W-1:0]  issue_qk = '0;
    logic [TAG_W-1:0]  issue_tag;
    logic              cdb_valid = 1'b0;
    logic [TAG_W-1:0]  cdb_tag = '0;
    logic [DATA_W-1:0] cdb_data = '0;
    logic              fu_valid;
    logic              fu_ready = 1'b0;
    logic              fu_op;
    logic [DATA_W-1:0] fu_a;
    logic [DATA_W-1:0] fu_b;
    logic [TAG_W-1:0]  fu_tag;
    logic [2:0]        busy_count;

    always #5 clock = ~clock;

    reservation_station_add #(.DEPTH(DEPTH), .TAG_BASE(TB_BASE)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_vj    (issue_vj),
        .issue_qj    (issue_qj),
        .issue_vk    (issue_vk),
        .issue_qk    (issue_qk),
        .issue_tag   (issue_tag),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .fu_valid    (fu_valid),
        .fu_ready    (fu_ready),
        .fu_op       (fu_op),
        .fu_a        (fu_a),
        .fu_b        (fu_b),
        .fu_tag      (fu_tag),
        .busy_count  (busy_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Reference model: entries kept as plain arrays, age is an issue sequence number.
    bit                m_busy [DEPTH];
    bit                m_op   [DEPTH];
    logic [DATA_W-1:0] m_vj   [DEPTH];
    logic [DATA_W-1:0] m_vk   [DEPTH];
    logic [TAG_W-1:0]  m_qj   [DEPTH];
    logic [TAG_W-1:0]  m_qk   [DEPTH];
    int                m_seq  [DEPTH];
    int                seq_ctr;
    bit                m_fv;
    bit                m_fop;
    logic [DATA_W-1:0] m_fa;
    logic [DATA_W-1:0] m_fb;
    logic [TAG_W-1:0]  m_ftag;

    function automatic int m_first_free();
        for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_busy[i] = 0; m_op[i] = 0; m_vj[i] = '0; m_vk[i] = '0;
            m_qj[i] = '0; m_qk[i] = '0; m_seq[i] = 0;
        end
        seq_ctr = 0;
        m_fv = 0; m_fop = 0; m_fa = '0; m_fb = '0; m_ftag = '0;
    endtask

    task automatic model_check();
        int ff;
        int cnt;
        ff  = m_first_free();
        cnt = 0;
        for (int i = 0; i < DEPTH; i++) cnt += int'(m_busy[i]);
        chk("issue_ready", issue_ready, (ff >= 0) ? 1 : 0);
        if (ff >= 0) chk("issue_tag", issue_tag, TB_BASE + ff);
        chk("busy_count", busy_count, cnt);
        chk("fu_valid", fu_valid, m_fv);
        if (m_fv) begin
            chk("fu_op", fu_op, m_fop);
            chk("fu_a", fu_a, m_fa);
            chk("fu_b", fu_b, m_fb);
            chk("fu_tag", fu_tag, m_ftag);
        end
    endtask

    task automatic model_step();
        int ff;
        int sel;
        bit load;
        bit snoop;
        ff  = m_first_free();
        sel = -1;
        for (int i = 0; i < DEPTH; i++)
            if (m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0 && (sel < 0 || m_seq[i] < m_seq[sel]))
                sel = i;
        load  = (sel >= 0) && (!m_fv || fu_ready);
        snoop = cdb_valid && (cdb_tag != 0);
        if (load) begin
            m_fv = 1; m_fop = m_op[sel]; m_fa = m_vj[sel]; m_fb = m_vk[sel];
            m_ftag = TAG_W'(TB_BASE + sel);
        end else if (fu_ready) begin
            m_fv = 0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (m_busy[i] && snoop && m_qj[i] == cdb_tag) begin m_vj[i] = cdb_data; m_qj[i] = 0; end
            if (m_busy[i] && snoop && m_qk[i] == cdb_tag) begin m_vk[i] = cdb_data; m_qk[i] = 0; end
        end
        if (load) m_busy[sel] = 0;
        if (issue_valid && ff >= 0) begin
            m_busy[ff] = 1; m_op[ff] = issue_op; m_seq[ff] = seq_ctr; seq_ctr++;
            if (snoop && issue_qj == cdb_tag) begin m_vj[ff] = cdb_data; m_qj[ff] = 0; end
            else begin m_vj[ff] = issue_vj; m_qj[ff] = issue_qj; end
            if (snoop && issue_qk == cdb_tag) begin m_vk[ff] = cdb_data; m_qk[ff] = 0; end
            else begin m_vk[ff] = issue_vk; m_qk[ff] = issue_qk; end
        end
    endtask

    task automatic tick();
        @(negedge clock);
        model_check();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_issue(input bit v, input bit op, input logic [DATA_W-1:0] vj,
                             input logic [TAG_W-1:0] qj, input logic [DATA_W-1:0] vk,
                             input logic [TAG_W-1:0] qk);
        issue_valid = v; issue_op = op; issue_vj = vj; issue_qj = qj; issue_vk = vk; issue_qk = qk;
    endtask

    task automatic set_cdb(input bit v, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        cdb_valid = v; cdb_tag = t; cdb_data = d;
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_fu_valid"}, fu_valid, 0);
        chk({pfx, "_fu_op"}, fu_op, 0);
        chk({pfx, "_fu_a"}, fu_a, 0);
        chk({pfx, "_fu_b"}, fu_b, 0);
        chk({pfx, "_fu_tag"}, fu_tag, 0);
        chk({pfx, "_busy_count"}, busy_count, 0);
        chk({pfx, "_issue_ready"}, issue_ready, 1);
        chk({pfx, "_issue_tag"}, issue_tag, TB_BASE);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("por");
        resetn = 1'b1;

        // Ready add issues and reaches the adder one cycle after allocation.
        fu_ready = 1'b1;
        set_issue(1, OP_ADD, 16'd5, 3'd0, 16'd7, 3'd0);
        tick();
        set_issue(0, OP_ADD, '0, '0, '0, '0);
        tick();
        chk("t2_fu_valid", fu_valid, 1);
        chk("t2_fu_a", fu_a, 5);
        chk("t2_fu_b", fu_b, 7);
        chk("t2_fu_tag", fu_tag, 1);
        tick();

        // Sub waiting on tag 4, satisfied by a later broadcast.
        set_issue(1, OP_SUB, 16'h1234, 3'd4, 16'd3, 3'd0);
        tick();
        set_issue(0, OP_ADD, '0, '0, '0, '0);
        tick();
        tick();
        set_cdb(1, 3'd4, 16'd10);
        tick();
        set_cdb(0, '0, '0);
        tick();
        chk("t3_fu_valid", fu_valid, 1);
        chk("t3_fu_a", fu_a, 10);
        chk("t3_fu_b", fu_b, 3);
        chk("t3_fu_op", fu_op, 1);
        tick();

        // Operand arrives on the CDB in the very cycle it is issued.
        set_issue(1, OP_ADD, 16'hAAAA, 3'd5, 16'd1, 3'd0);
        set_cdb(1, 3'd5, 16'h00FF);
        tick();
        set_issue(0, OP_ADD, '0, '0, '0, '0);
        set_cdb(0, '0, '0);
        tick();
        chk("t4_fu_valid", fu_valid, 1);
        chk("t4_fu_a", fu_a, 16'h00FF);
        tick();

        // Younger ready entry overtakes an older waiting one; tag 0 broadcast is ignored.
        set_issue(1, OP_ADD, 16'd1, 3'd6, 16'd2, 3'd0);
        tick();
        set_issue(1, OP_ADD, 16'd3, 3'd0, 16'd4, 3'd0);
        set_cdb(1, 3'd0, 16'hDEAD);
        tick();
        set_issue(0, OP_ADD, '0, '0, '0, '0);
        set_cdb(0, '0, '0);
        tick();
        chk("t6_first_a", fu_a, 3);
        chk("t6_first_tag", fu_tag, 2);
        set_cdb(1, 3'd6, 16'd9);
        tick();
        set_cdb(0, '0, '0);
        tick();
        chk("t6_second_a", fu_a, 9);
        chk("t6_second_b", fu_b, 2);
        chk("t6_second_tag", fu_tag, 1);
        tick();

        // Stall the adder until the station is full, then drain oldest-first.
        fu_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_issue(1, OP_ADD, DATA_W'(10 + i), 3'd0, DATA_W'(20 + i), 3'd0);
            tick();
        end
        set_issue(0, OP_ADD, '0, '0, '0, '0);
        chk("t5_full_ready", issue_ready, 0);
        chk("t5_full_count", busy_count, 3);
        repeat (3) tick();
        chk("t5_held_a", fu_a, 10);
        chk("t5_held_valid", fu_valid, 1);
        fu_ready = 1'b1;
        tick();
        chk("t5_drain1_a", fu_a, 11);
        chk("t5_drain1_ready", issue_ready, 1);
        chk("t5_drain1_tag", issue_tag, 2);
        tick();
        chk("t5_drain2_a", fu_a, 12);
        tick();
        chk("t5_drain3_a", fu_a, 13);
        tick();
        chk("t5_empty_valid", fu_valid, 0);

        // Asynchronous reset while full and stalled.
        fu_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_issue(1, OP_SUB, DATA_W'(40 + i), 3'd0, DATA_W'(50 + i), 3'd0);
            tick();
        end
        set_issue(0, OP_ADD, '0, '0, '0, '0);
        chk("t1_pre_count", busy_count, 3);
        chk("t1_pre_valid", fu_valid, 1);
        @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("t1_rst");
        model_reset();
        @(posedge clock);
        #1;
        resetn = 1'b1;
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            set_issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DATA_W'($urandom),
                      ($urandom_range(0, 2) == 0) ? TAG_W'($urandom_range(1, 7)) : 3'd0,
                      DATA_W'($urandom),
                      ($urandom_range(0, 2) == 0) ? TAG_W'($urandom_range(1, 7)) : 3'd0);
            set_cdb(1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 7)), DATA_W'($urandom));
            fu_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        set_issue(0, OP_ADD, '0, '0, '0, '0);
        fu_ready = 1'b1;
        for (int n = 0; n < 28; n++) begin
            set_cdb(1, TAG_W'((n % 7) + 1), DATA_W'($urandom));
            tick();
        end
        set_cdb(0, '0, '0);
        tick();
        chk("final_busy_count", busy_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
